ofs_avmm_rr_mux: RTL
====================

Name: ofs_avmm_rr_mux

Overview:
- Parametrised N-source to 1-sink AVMM multiplexer with bursts.
- Round-robin arbitration across NUM_SRC user-side AVMM sources onto one sink port (e.g. shared EMIF or CSR fabric).
- Tracks outstanding reads in a tag FIFO and routes each readdatavalid beat back to the issuing source.
- Holds the grant for the full length of a write burst.

Parameters:
- NUM_SRC, 4, number of source ports (2..16).
- DATA_W, 64, data width.
- ADDR_W, 16, address width.
- BURST_W, 4, burstcount width; max burst = 2^(BURST_W-1).
- SYMB_W, 8, symbol width; BE_W = DATA_W/SYMB_W.
- MAX_PEND, 8, tag FIFO depth, i.e. maximum outstanding read commands (power of 2).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- s_write  in  NUM_SRC  per-source write.
- s_read  in  NUM_SRC  per-source read.
- s_address  in  NUM_SRC*ADDR_W  packed addresses; source i at [i*ADDR_W +: ADDR_W].
- s_writedata  in  NUM_SRC*DATA_W  packed write data.
- s_burstcount  in  NUM_SRC*BURST_W  packed burstcount.
- s_byteenable  in  NUM_SRC*BE_W  packed byteenable.
- s_waitrequest  out  NUM_SRC  per-source waitrequest.
- s_readdatavalid  out  NUM_SRC  per-source read data valid.
- s_readdata  out  DATA_W  shared read data, broadcast to all sources.
- s_writeresponsevalid  out  NUM_SRC  per-source write response.
- m_write, m_read  out  1  sink command.
- m_address  out  ADDR_W  sink address.
- m_writedata  out  DATA_W  sink write data.
- m_burstcount  out  BURST_W  sink burstcount.
- m_byteenable  out  BE_W  sink byteenable.
- m_waitrequest  in  1  sink waitrequest.
- m_readdatavalid  in  1  sink read data valid.
- m_readdata  in  DATA_W  sink read data.
- m_writeresponsevalid  in  1  sink write response.

Behaviour:
- Reset: clk/rst_n only, rst_n asynchronous active-low as decided. While rst_n=0:
  - s_waitrequest = all 1s.
  - m_write = m_read = 0.
  - s_readdatavalid = s_writeresponsevalid = 0.
  - Priority pointer = 0; lock cleared; FIFOs empty; beat counters 0.
  - Reset mid-burst or with reads pending discards all state; late sink responses after reset are dropped.
- Request vector: req[i] = s_write[i] | (s_read[i] & ~rd_full).
  - rd_full uses registered count. No push while full, even if a pop occurs in the same cycle.
- Arbitration (combinational, zero added command latency):
  - When unlocked, grant the first req[i] at or after the pointer, wrapping modulo NUM_SRC.
  - Pointer := grant+1 (mod NUM_SRC) on each accepted command beat that ends a transaction: a read, or the last write beat.
- Accept: m_* driven from the granted source; accept = (m_write|m_read) & ~m_waitrequest. s_waitrequest[g] = m_waitrequest; all other sources see 1.
- Write bursts, FSM IDLE/WBURST:
  - IDLE → WBURST when a write is accepted with burstcount>1. Load remaining beats = burstcount-1.
  - In WBURST the grant is locked to that source; each accepted write beat decrements the count; → IDLE when the count reaches 0.
  - Reads from the locked source are not issued in WBURST (m_read forced 0).
  - burstcount=0 is treated as 1.
- Reads:
  - On read accept, push {src id, burstcount} into the tag FIFO.
  - Each m_readdatavalid pulses s_readdatavalid[head.src] in the same cycle; s_readdata = m_readdata.
  - Head beat counter increments per beat; pop on the last beat.
  - m_readdatavalid with FIFO empty is dropped. An error flag is asserted only in simulation.
  - Push and pop in the same cycle are allowed when not full; count is unchanged.
- Same-cycle read and write from one source: write wins; read stays waited.

Optional Feature:
- OFS_AVMM_MUX_WRRESP_EN defined:
  - Second FIFO (depth MAX_PEND) stores the src id on the last accepted write beat.
  - m_writeresponsevalid pops it and pulses s_writeresponsevalid[src].
  - Writes are masked from arbitration when this FIFO is full.
- Undefined:
  - No write FIFO; s_writeresponsevalid tied 0; m_writeresponsevalid ignored.

Test Plan:
- Sources 0,2 issue single reads in the same cycle, m_waitrequest=0 → source 0 granted at cycle 0, source 2 at cycle 1. Sink returns 0xA then 0xB → s_readdatavalid 0b0001 then 0b0100.
- Source 1 issues a 4-beat write while source 3 requests continuously → 4 contiguous source-1 beats on m_write, then source 3 granted; pointer = 2 afterwards.
- MAX_PEND=8: source 0 issues 9 reads with no responses → 9th held with s_waitrequest[0]=1. One response arrives → 9th accepted the cycle after the pop.
- Read with burstcount=4 from source 3, interleaved with a source-0 single read → 4 beats to source 3, then 1 to source 0, in order.
- rst_n asserted during WBURST beat 2 → m_write=0 immediately, s_waitrequest=all 1s. After release, a fresh source-2 write is granted first (pointer=0, source 2 lowest requester).
- Macro on: writes from sources 1,2, then two m_writeresponsevalid pulses → s_writeresponsevalid 0b0010 then 0b0100. Macro off → outputs stay 0.

Source files
------------

// File: rtl/ofs_avmm_rr_mux.sv
// N-source to 1-sink AVMM multiplexer: round-robin arbitration, write-burst grant lock,
// read-response routing through a tag FIFO. Define OFS_AVMM_MUX_WRRESP_EN to route write responses.
module ofs_avmm_rr_mux #(
    parameter int NUM_SRC  = 4,
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 16,
    parameter int BURST_W  = 4,
    parameter int SYMB_W   = 8,
    parameter int MAX_PEND = 8,
    parameter int BE_W     = DATA_W / SYMB_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_SRC-1:0]         s_write,
    input  logic [NUM_SRC-1:0]         s_read,
    input  logic [NUM_SRC*ADDR_W-1:0]  s_address,
    input  logic [NUM_SRC*DATA_W-1:0]  s_writedata,
    input  logic [NUM_SRC*BURST_W-1:0] s_burstcount,
    input  logic [NUM_SRC*BE_W-1:0]    s_byteenable,
    output logic [NUM_SRC-1:0]         s_waitrequest,
    output logic [NUM_SRC-1:0]         s_readdatavalid,
    output logic [DATA_W-1:0]          s_readdata,
    output logic [NUM_SRC-1:0]         s_writeresponsevalid,
    output logic                       m_write,
    output logic                       m_read,
    output logic [ADDR_W-1:0]          m_address,
    output logic [DATA_W-1:0]          m_writedata,
    output logic [BURST_W-1:0]         m_burstcount,
    output logic [BE_W-1:0]            m_byteenable,
    input  logic                       m_waitrequest,
    input  logic                       m_readdatavalid,
    input  logic [DATA_W-1:0]          m_readdata,
    input  logic                       m_writeresponsevalid
);

    localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int PTR_W = (MAX_PEND > 1) ? $clog2(MAX_PEND) : 1;
    localparam int CNT_W = PTR_W + 1;

    // Handshake: a command beat transfers on a cycle where m_write|m_read is high and
    // m_waitrequest is low; the granted source sees m_waitrequest, every other source sees 1.
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_WBURST = 1'b1
    } state_t;

    state_t               state, state_nxt;
    logic [SRC_W-1:0]     rr_ptr;
    logic [SRC_W-1:0]     lock_src;
    logic [BURST_W-1:0]   wr_rem, wr_rem_nxt;
    logic [NUM_SRC-1:0]   req;
    logic [SRC_W-1:0]     gnt;
    logic                 gnt_valid;
    logic [SRC_W:0]       arb_idx;
    logic [SRC_W-1:0]     arb_sel;
    logic [BURST_W-1:0]   g_bc;
    logic [BURST_W-1:0]   g_bc_eff;
    logic                 g_write;
    logic                 g_read;
    logic                 accept;
    logic                 last_wbeat;
    logic                 rd_full;
    logic                 wr_full;

    // Read tag FIFO
    logic [SRC_W-1:0]     rd_src_mem [MAX_PEND];
    logic [BURST_W-1:0]   rd_len_mem [MAX_PEND];
    logic [PTR_W-1:0]     rd_wp, rd_rp;
    logic [CNT_W-1:0]     rd_cnt;
    logic [BURST_W-1:0]   rd_beat;
    logic                 rd_push, rd_pop, rd_beat_ok;
    logic [SRC_W-1:0]     rd_head_src;
    logic [BURST_W-1:0]   rd_head_len;

    always_comb begin
        req = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            req[i] = (s_write[i] & ~wr_full) | (s_read[i] & ~rd_full);
        end
    end

    // Scan from the pointer downward-in-priority so the nearest requester is assigned last.
    always_comb begin
        gnt       = rr_ptr;
        gnt_valid = 1'b0;
        arb_idx   = '0;
        arb_sel   = '0;
        if (state == ST_WBURST) begin
            gnt       = lock_src;
            gnt_valid = 1'b1;
        end else begin
            for (int k = NUM_SRC - 1; k >= 0; k--) begin
                arb_idx = {1'b0, rr_ptr} + (SRC_W + 1)'(k);
                if (arb_idx >= (SRC_W + 1)'(NUM_SRC)) begin
                    arb_idx = arb_idx - (SRC_W + 1)'(NUM_SRC);
                end
                arb_sel = arb_idx[SRC_W-1:0];
                if (req[arb_sel]) begin
                    gnt       = arb_sel;
                    gnt_valid = 1'b1;
                end
            end
        end
    end

    always_comb begin
        m_address    = s_address[int'(gnt)*ADDR_W +: ADDR_W];
        m_writedata  = s_writedata[int'(gnt)*DATA_W +: DATA_W];
        m_byteenable = s_byteenable[int'(gnt)*BE_W +: BE_W];
        g_bc         = s_burstcount[int'(gnt)*BURST_W +: BURST_W];
        m_burstcount = g_bc;
        g_bc_eff     = (g_bc == '0) ? BURST_W'(1) : g_bc;
    end

    // A write from the granted source always takes precedence over its read.
    assign g_write = s_write[gnt] & ~wr_full;
    assign g_read  = s_read[gnt] & ~s_write[gnt] & ~rd_full & (state == ST_IDLE);
    assign m_write = rst_n & gnt_valid & g_write;
    assign m_read  = rst_n & gnt_valid & g_read;
    assign accept  = (m_write | m_read) & ~m_waitrequest;

    always_comb begin
        s_waitrequest = '1;
        if (m_write | m_read) begin
            s_waitrequest[gnt] = m_waitrequest;
        end
    end

    assign last_wbeat = (state == ST_IDLE) ? (g_bc_eff == BURST_W'(1)) : (wr_rem == BURST_W'(1));

    always_comb begin
        state_nxt  = state;
        wr_rem_nxt = wr_rem;
        case (state)
            ST_IDLE: begin
                if (accept && m_write && (g_bc_eff != BURST_W'(1))) begin
                    state_nxt  = ST_WBURST;
                    wr_rem_nxt = g_bc_eff - BURST_W'(1);
                end
            end
            ST_WBURST: begin
                if (accept && m_write) begin
                    wr_rem_nxt = wr_rem - BURST_W'(1);
                    if (wr_rem == BURST_W'(1)) begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            wr_rem   <= '0;
            lock_src <= '0;
            rr_ptr   <= '0;
        end else begin
            state  <= state_nxt;
            wr_rem <= wr_rem_nxt;
            if (state == ST_IDLE && state_nxt == ST_WBURST) begin
                lock_src <= gnt;
            end
            if (accept && (m_read || (m_write && last_wbeat))) begin
                if (gnt == SRC_W'(NUM_SRC - 1)) begin
                    rr_ptr <= '0;
                end else begin
                    rr_ptr <= gnt + SRC_W'(1);
                end
            end
        end
    end

    // Full is judged on the registered count, so a same-cycle pop never frees a slot early.
    assign rd_full     = (rd_cnt == CNT_W'(MAX_PEND));
    assign rd_push     = accept & m_read;
    assign rd_head_src = rd_src_mem[rd_rp];
    assign rd_head_len = rd_len_mem[rd_rp];
    assign rd_beat_ok  = m_readdatavalid & (rd_cnt != '0);
    assign rd_pop      = rd_beat_ok & (rd_beat == rd_head_len - BURST_W'(1));
    assign s_readdata  = m_readdata;

    always_comb begin
        s_readdatavalid = '0;
        if (rst_n && rd_beat_ok) begin
            s_readdatavalid[rd_head_src] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_push) begin
            rd_src_mem[rd_wp] <= gnt;
            rd_len_mem[rd_wp] <= g_bc_eff;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_wp   <= '0;
            rd_rp   <= '0;
            rd_cnt  <= '0;
            rd_beat <= '0;
        end else begin
            if (rd_push) begin
                rd_wp <= rd_wp + PTR_W'(1);
            end
            if (rd_pop) begin
                rd_rp   <= rd_rp + PTR_W'(1);
                rd_beat <= '0;
            end else if (rd_beat_ok) begin
                rd_beat <= rd_beat + BURST_W'(1);
            end
            if (rd_push && !rd_pop) begin
                rd_cnt <= rd_cnt + CNT_W'(1);
            end else if (rd_pop && !rd_push) begin
                rd_cnt <= rd_cnt - CNT_W'(1);
            end
        end
    end

`ifdef OFS_AVMM_MUX_WRRESP_EN
    logic [SRC_W-1:0] wr_src_mem [MAX_PEND];
    logic [PTR_W-1:0] wr_wp, wr_rp;
    logic [CNT_W-1:0] wr_cnt;
    logic             wr_push, wr_pop;

    assign wr_full = (wr_cnt == CNT_W'(MAX_PEND));
    assign wr_push = accept & m_write & last_wbeat;
    assign wr_pop  = m_writeresponsevalid & (wr_cnt != '0);

    always_comb begin
        s_writeresponsevalid = '0;
        if (rst_n && wr_pop) begin
            s_writeresponsevalid[wr_src_mem[wr_rp]] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_push) begin
            wr_src_mem[wr_wp] <= gnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_wp  <= '0;
            wr_rp  <= '0;
            wr_cnt <= '0;
        end else begin
            if (wr_push) begin
                wr_wp <= wr_wp + PTR_W'(1);
            end
            if (wr_pop) begin
                wr_rp <= wr_rp + PTR_W'(1);
            end
            if (wr_push && !wr_pop) begin
                wr_cnt <= wr_cnt + CNT_W'(1);
            end else if (wr_pop && !wr_push) begin
                wr_cnt <= wr_cnt - CNT_W'(1);
            end
        end
    end
`else
    logic unused_wrresp;
    assign unused_wrresp        = m_writeresponsevalid;
    assign wr_full              = 1'b0;
    assign s_writeresponsevalid = '0;
`endif

`ifndef SYNTHESIS
    // A read beat with no outstanding tag is discarded; flag it in simulation.
    orphan_read_beat: assert property (@(posedge clk) disable iff (!rst_n)
        !(m_readdatavalid && rd_cnt == '0));
`endif

endmodule
